// File: rtl/seq_div_32_pkg.sv
// Shared constants for the sequential divider: width, counter size, FSM encodings,
// and the quotient reported on divide-by-zero.
package seq_div_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [WIDTH-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/rc_add_sub_32.sv
// 32-bit ripple-carry adder/subtractor: Y = A + B (SnA=0) or A - B (SnA=1).
// Cout is the final carry; when subtracting it is high when there is no borrow.
module rc_add_sub_32
    import seq_div_32_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SnA,
    output logic [WIDTH-1:0] Y,
    output logic             Cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_x;

    always_comb begin
        b_x      = B ^ {WIDTH{SnA}};
        carry    = '0;
        carry[0] = SnA;
        Y        = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            Y[i]       = A[i] ^ b_x[i] ^ carry[i];
            carry[i+1] = (A[i] & b_x[i]) | (carry[i] & (A[i] ^ b_x[i]));
        end
        Cout = carry[WIDTH];
    end

endmodule

// File: rtl/seq_div_32.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per cycle.
// START/DONE handshake; QUO, REM and DIV0 are registered and held between operations.
module seq_div_32
    import seq_div_32_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DVND,
    input  logic [WIDTH-1:0] DVSR,
    output logic [WIDTH-1:0] QUO,
    output logic [WIDTH-1:0] REM,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV0
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;

    // The stored partial remainder never exceeds the divisor, so its 33rd bit is
    // always zero between iterations; only the shifted value needs WIDTH+1 bits.
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;
    logic             accept;

    assign r_sh = {r_q, q_q[WIDTH-1]};

    rc_add_sub_32 u_sub (
        .A    (r_sh[WIDTH-1:0]),
        .B    (d_q),
        .SnA  (1'b1),
        .Y    (trial),
        .Cout (no_borrow)
    );

    assign accept = r_sh[WIDTH] | no_borrow;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (START) begin
                    if (DVSR != '0) begin
                        state_d = ST_RUN;
                        r_d     = '0;
                        q_d     = DVND;
                        d_d     = DVSR;
                        cnt_d   = CNT_W'(WIDTH);
                        div0_d  = 1'b0;
                    end else begin
                        state_d = ST_FIN;
                        quo_d   = DIV0_QUO;
                        rem_d   = DVND;
                        div0_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                q_d   = {q_q[WIDTH-2:0], accept};
                r_d   = accept ? trial : r_sh[WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                // Results are loaded on the last iteration so they are valid with DONE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                    quo_d   = q_d;
                    rem_d   = r_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
        end
    end

    assign QUO  = quo_q;
    assign REM  = rem_q;
    assign DIV0 = div0_q;
    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_FIN);

endmodule
